pc_unit: RTL and testbench

//  Parametrised fetch-stage program counter: holds the fetch address and selects the next PC

---
 rtl/pc_unit.sv | 168 ++++++++++++++++
 tb/tb_pc_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter with interrupt entry/return, alignment fault flag and
// optional return-address stack (enabled by defining PC_RAS_EN).
module pc_unit #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int              STEP      = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Clr_n,
  input  logic              StallF,
  input  logic [2:0]        Source,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic [ADDR_W-1:0] JumpTarget,
  input  logic [ADDR_W-1:0] RegTarget,
  input  logic [ADDR_W-1:0] EpcIn,
  input  logic              IrqIn,
  output logic [ADDR_W-1:0] Address,
  output logic [ADDR_W-1:0] PcPlusStep,
  output logic              IrqTaken,
  output logic [ADDR_W-1:0] SavedPc,
  output logic              InHandler,
  output logic              AddrFault,
  output logic              RasHit
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

  typedef enum logic {ST_RUN, ST_HANDLER} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [ADDR_W-1:0] saved_pc_q, saved_pc_d;
  logic              irq_pend_q, irq_pend_d;
  logic              irq_taken_q, irq_taken_d;
  logic              fault_q, fault_d;
  logic              ras_hit_q, ras_hit_d;
  logic              irq_entry;
  logic [ADDR_W-1:0] pc_plus_step;

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_wr_ptr_q, ras_wr_ptr_d;
  logic [CNT_W-1:0]  ras_count_q, ras_count_d;
  logic [PTR_W-1:0]  ras_top_idx, ras_ptr_inc;
  logic              ras_push, ras_pop;

  // Write pointer names the next free slot; the newest entry sits one below it (circularly).
  always_comb begin
    ras_top_idx = (ras_wr_ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_wr_ptr_q - PTR_W'(1);
    ras_ptr_inc = (ras_wr_ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_wr_ptr_q + PTR_W'(1);
    ras_wr_ptr_d = ras_wr_ptr_q;
    ras_count_d  = ras_count_q;
    if (ras_push) begin
      ras_wr_ptr_d = ras_ptr_inc;
      if (ras_count_q != CNT_W'(RAS_DEPTH)) ras_count_d = ras_count_q + CNT_W'(1);
    end else if (ras_pop) begin
      ras_wr_ptr_d = ras_top_idx;
      ras_count_d  = ras_count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      ras_wr_ptr_q <= '0;
      ras_count_q  <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      ras_wr_ptr_q <= ras_wr_ptr_d;
      ras_count_q  <= ras_count_d;
      if (ras_push) ras_q[ras_wr_ptr_q] <= pc_plus_step;
    end
  end
`endif

  assign pc_plus_step = address_q + ADDR_W'(STEP);
  assign irq_entry    = (state_q == ST_RUN) && (irq_pend_q || IrqIn);

  // Interrupt entry outranks stall, which outranks the Source select.
  always_comb begin
    address_d   = address_q;
    saved_pc_d  = saved_pc_q;
    state_d     = state_q;
    irq_pend_d  = irq_pend_q;
    irq_taken_d = 1'b0;
    ras_hit_d   = ras_hit_q;
`ifdef PC_RAS_EN
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
`endif
    if (state_q == ST_HANDLER && IrqIn) irq_pend_d = 1'b1;

    if (irq_entry) begin
      address_d   = EXC_VEC;
      saved_pc_d  = address_q;
      state_d     = ST_HANDLER;
      irq_pend_d  = 1'b0;
      irq_taken_d = 1'b1;
      ras_hit_d   = 1'b0;
    end else if (!StallF) begin
      ras_hit_d = 1'b0;
      case (Source)
        3'd1: address_d = BranchTarget;
        3'd2: address_d = JumpTarget;
        3'd3: address_d = RegTarget;
        3'd4: begin
          address_d = EpcIn;
          state_d   = ST_RUN;
        end
        3'd5: begin
          address_d = JumpTarget;
`ifdef PC_RAS_EN
          ras_push  = 1'b1;
`endif
        end
        3'd6: begin
`ifdef PC_RAS_EN
          if (ras_count_q != '0) begin
            address_d = ras_q[ras_top_idx];
            ras_pop   = 1'b1;
            ras_hit_d = 1'b1;
          end else begin
            address_d = RegTarget;
          end
`else
          address_d = RegTarget;
`endif
        end
        default: address_d = pc_plus_step;
      endcase
    end

    fault_d = |(address_d & ALIGN_MASK);
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state_q     <= ST_RUN;
      address_q   <= RESET_VEC;
      saved_pc_q  <= '0;
      irq_pend_q  <= 1'b0;
      irq_taken_q <= 1'b0;
      fault_q     <= 1'b0;
      ras_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      saved_pc_q  <= saved_pc_d;
      irq_pend_q  <= irq_pend_d;
      irq_taken_q <= irq_taken_d;
      fault_q     <= fault_d;
      ras_hit_q   <= ras_hit_d;
    end
  end

  assign Address    = address_q;
  assign PcPlusStep = pc_plus_step;
  assign IrqTaken   = irq_taken_q;
  assign SavedPc    = saved_pc_q;
  assign InHandler  = (state_q == ST_HANDLER);
  assign AddrFault  = fault_q;
  assign RasHit     = ras_hit_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; the return-stack section follows PC_RAS_EN.
module tb_pc_unit;

  logic        Clk;
  logic        Clr_n;
  logic        StallF;
  logic [2:0]  Source;
  logic [31:0] BranchTarget, JumpTarget, RegTarget, EpcIn;
  logic        IrqIn;
  logic [31:0] Address, PcPlusStep, SavedPc;
  logic        IrqTaken, InHandler, AddrFault, RasHit;

  int vectors;
  int miscompares;

  pc_unit dut (
    .Clk(Clk), .Clr_n(Clr_n), .StallF(StallF), .Source(Source),
    .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .RegTarget(RegTarget),
    .EpcIn(EpcIn), .IrqIn(IrqIn), .Address(Address), .PcPlusStep(PcPlusStep),
    .IrqTaken(IrqTaken), .SavedPc(SavedPc), .InHandler(InHandler),
    .AddrFault(AddrFault), .RasHit(RasHit)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic apply_stimulus(input logic stall, input logic [2:0] src);
    StallF = stall;
    Source = src;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic taken, input logic inh,
                             input logic fault, input logic hit);
    check_output({tag, ".IrqTaken"},  32'(IrqTaken),  32'(taken));
    check_output({tag, ".InHandler"}, 32'(InHandler), 32'(inh));
    check_output({tag, ".AddrFault"}, 32'(AddrFault), 32'(fault));
    check_output({tag, ".RasHit"},    32'(RasHit),    32'(hit));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    Clr_n = 1'b0; StallF = 1'b0; Source = 3'd0; IrqIn = 1'b0;
    BranchTarget = '0; JumpTarget = '0; RegTarget = '0; EpcIn = '0;

    #12;
    check_output("reset.Address", Address, 32'h3000);
    check_output("reset.SavedPc", SavedPc, 32'h0);
    check_output("reset.PcPlusStep", PcPlusStep, 32'h3004);
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    Clr_n = 1'b1;

    apply_stimulus(1'b0, 3'd0); check_output("seq1", Address, 32'h3004);
    apply_stimulus(1'b0, 3'd0); check_output("seq2", Address, 32'h3008);
    apply_stimulus(1'b0, 3'd0); check_output("seq3", Address, 32'h300C);
    apply_stimulus(1'b0, 3'd0); check_output("seq4", Address, 32'h3010);

    JumpTarget = 32'h3400;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 3'd2);
      check_output("stall_hold", Address, 32'h3010);
    end
    apply_stimulus(1'b0, 3'd2); check_output("jump", Address, 32'h3400);

    RegTarget = 32'h3010;
    apply_stimulus(1'b0, 3'd3); check_output("jr", Address, 32'h3010);

    IrqIn = 1'b1;
    apply_stimulus(1'b1, 3'd2);
    IrqIn = 1'b0;
    check_output("irq.Address", Address, 32'h4180);
    check_output("irq.SavedPc", SavedPc, 32'h3010);
    check_flags("irq", 1'b1, 1'b1, 1'b0, 1'b0);

    apply_stimulus(1'b0, 3'd0);
    check_output("handler_seq", Address, 32'h4184);
    check_flags("handler_seq", 1'b0, 1'b1, 1'b0, 1'b0);

    IrqIn = 1'b1;
    apply_stimulus(1'b0, 3'd0);
    IrqIn = 1'b0;
    check_output("handler_irq_pend", Address, 32'h4188);
    check_output("handler_still_in", 32'(InHandler), 32'd1);

    EpcIn = 32'h3010;
    apply_stimulus(1'b0, 3'd4);
    check_output("eret.Address", Address, 32'h3010);
    check_flags("eret", 1'b0, 1'b0, 1'b0, 1'b0);

    apply_stimulus(1'b0, 3'd0);
    check_output("pend_irq.Address", Address, 32'h4180);
    check_output("pend_irq.SavedPc", SavedPc, 32'h3010);
    check_flags("pend_irq", 1'b1, 1'b1, 1'b0, 1'b0);

    EpcIn = 32'h3020;
    apply_stimulus(1'b0, 3'd4);
    check_output("eret2", Address, 32'h3020);
    check_output("eret2.InHandler", 32'(InHandler), 32'd0);

    EpcIn = 32'h3030;
    apply_stimulus(1'b0, 3'd4);
    check_output("eret_in_run", Address, 32'h3030);
    check_output("eret_in_run.InHandler", 32'(InHandler), 32'd0);

    BranchTarget = 32'h3402;
    apply_stimulus(1'b0, 3'd1);
    check_output("branch_misaligned", Address, 32'h3402);
    check_output("branch_misaligned.AddrFault", 32'(AddrFault), 32'd1);
    apply_stimulus(1'b0, 3'd0);
    check_output("seq_misaligned", Address, 32'h3406);
    check_output("seq_misaligned.AddrFault", 32'(AddrFault), 32'd1);
    JumpTarget = 32'h3500;
    apply_stimulus(1'b0, 3'd2);
    check_output("realigned", Address, 32'h3500);
    check_output("realigned.AddrFault", 32'(AddrFault), 32'd0);

    apply_stimulus(1'b0, 3'd7);
    check_output("source7", Address, 32'h3504);

    RegTarget = 32'hFFFF_FFFC;
    apply_stimulus(1'b0, 3'd3);
    check_output("top.PcPlusStep", PcPlusStep, 32'h0);
    apply_stimulus(1'b0, 3'd0);
    check_output("wrap", Address, 32'h0);

`ifdef PC_RAS_EN
    RegTarget = 32'h3000;
    apply_stimulus(1'b0, 3'd3);
    for (int i = 0; i < 5; i++) begin
      JumpTarget = Address + 32'd4;
      apply_stimulus(1'b0, 3'd5);
    end
    check_output("calls_done", Address, 32'h3014);
    RegTarget = 32'h3800;
    apply_stimulus(1'b0, 3'd6); check_output("ret1", Address, 32'h3014);
    check_output("ret1.RasHit", 32'(RasHit), 32'd1);
    apply_stimulus(1'b0, 3'd6); check_output("ret2", Address, 32'h3010);
    apply_stimulus(1'b0, 3'd6); check_output("ret3", Address, 32'h300C);
    apply_stimulus(1'b0, 3'd6); check_output("ret4", Address, 32'h3008);
    check_output("ret4.RasHit", 32'(RasHit), 32'd1);
    apply_stimulus(1'b0, 3'd6); check_output("ret5_empty", Address, 32'h3800);
    check_output("ret5_empty.RasHit", 32'(RasHit), 32'd0);
    JumpTarget = 32'h3700;
    apply_stimulus(1'b0, 3'd5);
    apply_stimulus(1'b0, 3'd5);
`else
    JumpTarget = 32'h3600;
    apply_stimulus(1'b0, 3'd5);
    check_output("call_as_jump", Address, 32'h3600);
    RegTarget = 32'h3700;
    apply_stimulus(1'b0, 3'd6);
    check_output("ret_as_jr", Address, 32'h3700);
    check_output("ret_as_jr.RasHit", 32'(RasHit), 32'd0);
    JumpTarget = 32'h3704;
    apply_stimulus(1'b0, 3'd5);
`endif

    Clr_n = 1'b0;
    #2;
    check_output("midreset.Address", Address, 32'h3000);
    check_output("midreset.SavedPc", SavedPc, 32'h0);
    check_flags("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
    Clr_n = 1'b1;
    RegTarget = 32'h3900;
    apply_stimulus(1'b0, 3'd6);
    check_output("post_reset_ret", Address, 32'h3900);
    check_output("post_reset_ret.RasHit", 32'(RasHit), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
